// File: rtl/dircc_status_regfile.sv
// Per-device status register file: bus-visible state/extra/user words, sticky
// event flags with write-1-to-clear, per-slot interrupt enables and a hardware update port.
module dircc_status_regfile #(
    parameter int NUM_DEVS      = 4,
    parameter int ADDRESS_WIDTH = 15,
    parameter int BYTE_WIDTH    = 8,
    localparam int MEM_WIDTH    = 16,
    localparam int DEV_W        = (NUM_DEVS > 1) ? $clog2(NUM_DEVS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDRESS_WIDTH-1:0]   mem_address,
    input  logic                       mem_write,
    input  logic [MEM_WIDTH-1:0]       mem_writedata,
    output logic [MEM_WIDTH-1:0]       mem_readdata,
    input  logic                       hw_valid,
    output logic                       hw_ready,
    input  logic [DEV_W-1:0]           hw_dev,
    input  logic                       hw_exclusive,
    input  logic [15:0]                hw_state,
    input  logic [15:0]                hw_extra,
    output logic [NUM_DEVS*16-1:0]     dev_state,
    output logic                       irq
);

    localparam int SLOT_W = ADDRESS_WIDTH - 4;
    localparam int BPW    = MEM_WIDTH / BYTE_WIDTH;

    logic [15:0]           r_state [NUM_DEVS];
    logic [15:0]           r_extra [NUM_DEVS];
    logic [BYTE_WIDTH-1:0] r_user  [NUM_DEVS][4*BPW];
    logic [2:0]            r_evt   [NUM_DEVS];
    logic [2:0]            r_en    [NUM_DEVS];
    logic [MEM_WIDTH-1:0]  r_readdata;
    logic                  r_irq;

    logic [SLOT_W-1:0]     w_slot;
    logic [2:0]            w_word;
    logic                  w_unused_addr0;
    logic                  w_upd       [NUM_DEVS];
    logic                  w_wr        [NUM_DEVS];
    logic                  w_chg       [NUM_DEVS];
    logic [15:0]           w_new_state [NUM_DEVS];
    logic [2:0]            w_set       [NUM_DEVS];
    logic [2:0]            w_clr       [NUM_DEVS];
    logic [MEM_WIDTH-1:0]  w_rd;
    logic                  w_irq_any;

    assign w_slot         = mem_address[ADDRESS_WIDTH-1:4];
    assign w_word         = mem_address[3:1];
    assign w_unused_addr0 = mem_address[0];

    // A bus write to the state or extra word of the slot being updated takes the cycle.
    assign hw_ready = !(mem_write && (w_word[2:1] == 2'b00) && (int'(w_slot) == int'(hw_dev)));

    always_comb begin
        for (int i = 0; i < NUM_DEVS; i++) begin
            w_upd[i]       = hw_valid && hw_ready && (int'(hw_dev) == i);
            w_wr[i]        = mem_write && (int'(w_slot) == i);
            w_new_state[i] = hw_exclusive ? hw_state : (r_state[i] | hw_state);
            w_chg[i]       = w_upd[i] && (w_new_state[i] != r_state[i]);
            w_set[i]       = {w_chg[i] && r_evt[i][0],
                              w_upd[i] && (hw_extra != r_extra[i]),
                              w_chg[i]};
            w_clr[i]       = (w_wr[i] && (w_word == 3'd6)) ? mem_writedata[2:0] : 3'b000;
        end
    end

    always_comb begin
        w_rd      = '0;
        w_irq_any = 1'b0;
        for (int i = 0; i < NUM_DEVS; i++) begin
            w_irq_any = w_irq_any | (|(r_evt[i] & r_en[i]));
            if (int'(w_slot) == i) begin
                case (w_word)
                    3'd0:    w_rd = r_state[i];
                    3'd1:    w_rd = r_extra[i];
                    3'd6:    w_rd = {{(MEM_WIDTH-3){1'b0}}, r_evt[i]};
                    3'd7:    w_rd = {{(MEM_WIDTH-3){1'b0}}, r_en[i]};
                    default: begin
                        for (int k = 0; k < 4; k++) begin
                            if (w_word == 3'(k + 2)) begin
                                for (int b = 0; b < BPW; b++) begin
                                    w_rd[b*BYTE_WIDTH +: BYTE_WIDTH] = r_user[i][k*BPW+b];
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DEVS; i++) begin
                r_state[i] <= '0;
                r_extra[i] <= '0;
                r_evt[i]   <= '0;
                r_en[i]    <= '0;
                for (int b = 0; b < 4*BPW; b++) begin
                    r_user[i][b] <= '0;
                end
            end
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DEVS; i++) begin
                if (w_upd[i]) begin
                    r_state[i] <= w_new_state[i];
                    r_extra[i] <= hw_extra;
                end
                if (w_wr[i]) begin
                    case (w_word)
                        3'd0:    r_state[i] <= mem_writedata;
                        3'd1:    r_extra[i] <= mem_writedata;
                        3'd7:    r_en[i]    <= mem_writedata[2:0];
                        default: begin
                            for (int k = 0; k < 4; k++) begin
                                if (w_word == 3'(k + 2)) begin
                                    for (int b = 0; b < BPW; b++) begin
                                        r_user[i][k*BPW+b] <= mem_writedata[b*BYTE_WIDTH +: BYTE_WIDTH];
                                    end
                                end
                            end
                        end
                    endcase
                end
                // Clear first, then set, so a same-cycle event survives its own W1C.
                r_evt[i] <= (r_evt[i] & ~w_clr[i]) | w_set[i];
            end
            r_readdata <= w_rd;
            r_irq      <= w_irq_any;
        end
    end

    assign mem_readdata = r_readdata;
    assign irq          = r_irq;

    for (genvar g = 0; g < NUM_DEVS; g++) begin : g_dev_state
        assign dev_state[16*g +: 16] = r_state[g];
    end

endmodule

// File: tb/tb_dircc_status_regfile.sv
// Self-checking bench for dircc_status_regfile: scenario tasks with a reference
// model of the register file and a queue of expected read data.
module tb_dircc_status_regfile;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] mem_address = '0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_writedata = '0;
    logic [15:0] mem_readdata;
    logic        hw_valid = 1'b0;
    logic        hw_ready;
    logic [1:0]  hw_dev = '0;
    logic        hw_exclusive = 1'b0;
    logic [15:0] hw_state = '0;
    logic [15:0] hw_extra = '0;
    logic [63:0] dev_state;
    logic        irq;

    dircc_status_regfile dut (
        .clk(clk), .reset_n(reset_n), .mem_address(mem_address), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .hw_valid(hw_valid),
        .hw_ready(hw_ready), .hw_dev(hw_dev), .hw_exclusive(hw_exclusive), .hw_state(hw_state),
        .hw_extra(hw_extra), .dev_state(dev_state), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got, exp_v;
    logic [63:0] exp_ds;

    logic [15:0] m_state [4];
    logic [15:0] m_extra [4];
    logic [15:0] m_user  [4][4];
    logic [2:0]  m_evt   [4];
    logic [2:0]  m_en    [4];

    function automatic void model_clear();
        for (int d = 0; d < 4; d++) begin
            m_state[d] = '0; m_extra[d] = '0; m_evt[d] = '0; m_en[d] = '0;
            for (int k = 0; k < 4; k++) m_user[d][k] = '0;
        end
    endfunction

    function automatic void model_upd(input int d, input logic ex, input logic [15:0] st, input logic [15:0] xt);
        logic [15:0] ns;
        logic [2:0]  s;
        ns = ex ? st : (m_state[d] | st);
        s[0] = (ns != m_state[d]);
        s[1] = (xt != m_extra[d]);
        s[2] = s[0] && m_evt[d][0];
        m_evt[d] = m_evt[d] | s;
        m_state[d] = ns;
        m_extra[d] = xt;
    endfunction

    function automatic void model_wr(input int slot, input int w, input logic [15:0] d);
        if (slot < 4) begin
            case (w)
                0: m_state[slot] = d;
                1: m_extra[slot] = d;
                6: m_evt[slot] = m_evt[slot] & ~d[2:0];
                7: m_en[slot] = d[2:0];
                default: m_user[slot][w-2] = d;
            endcase
        end
    endfunction

    function automatic logic [15:0] model_rd(input int slot, input int w);
        if (slot >= 4) return 16'h0000;
        case (w)
            0: return m_state[slot];
            1: return m_extra[slot];
            6: return {13'b0, m_evt[slot]};
            7: return {13'b0, m_en[slot]};
            default: return m_user[slot][w-2];
        endcase
    endfunction

    function automatic logic [63:0] model_ds();
        return {m_state[3], m_state[2], m_state[1], m_state[0]};
    endfunction

    task automatic set_addr(input int slot, input int w);
        logic [10:0] s;
        logic [2:0]  ww;
        s  = slot[10:0];
        ww = w[2:0];
        mem_address = {s, ww, 1'($urandom_range(0, 1))};
    endtask

    task automatic bus_wr(input int slot, input int w, input logic [15:0] d);
        set_addr(slot, w);
        mem_writedata = d;
        mem_write = 1'b1;
        @(posedge clk); #1;
        mem_write = 1'b0;
        model_wr(slot, w, d);
    endtask

    task automatic rd(input int slot, input int w, output logic [15:0] g);
        set_addr(slot, w);
        @(posedge clk); #1;
        g = mem_readdata;
    endtask

    task automatic hw_upd(input int d, input logic ex, input logic [15:0] st, input logic [15:0] xt);
        hw_dev = d[1:0]; hw_exclusive = ex; hw_state = st; hw_extra = xt;
        hw_valid = 1'b1;
        @(posedge clk); #1;
        hw_valid = 1'b0;
        model_upd(d, ex, st, xt);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_clear();
        #1;
        n_tests++; if (hw_ready !== 1'b1) begin $display("FAIL reset_hw_ready got %b exp 1", hw_ready); n_fail++; end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back(16'h0000);
            rd(0, w, got);
            exp_v = exp_q.pop_front();
            n_tests++; if (got !== exp_v) begin $display("FAIL reset_rd_w%0d got %h exp %h", w, got, exp_v); n_fail++; end
        end
        n_tests++; if (irq !== 1'b0) begin $display("FAIL reset_irq got %b exp 0", irq); n_fail++; end
        n_tests++; if (dev_state !== 64'h0) begin $display("FAIL reset_dev_state got %h exp 0", dev_state); n_fail++; end
    endtask

    task automatic test_hw_or();
        hw_upd(1, 1'b0, 16'h0003, 16'h00AA);
        n_tests++; if (dev_state[31:16] !== 16'h0003) begin $display("FAIL or_first_state got %h exp 0003", dev_state[31:16]); n_fail++; end
        hw_upd(1, 1'b0, 16'h0004, 16'h00AA);
        n_tests++; if (dev_state[31:16] !== 16'h0007) begin $display("FAIL or_state got %h exp 0007", dev_state[31:16]); n_fail++; end
        exp_q.push_back(16'h00AA);
        rd(1, 1, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL or_extra got %h exp %h", got, exp_v); n_fail++; end
        exp_q.push_back(16'h0007);
        rd(1, 6, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL or_events got %h exp %h", got, exp_v); n_fail++; end
    endtask

    task automatic test_exclusive_irq();
        hw_upd(2, 1'b0, 16'h00FF, 16'h0000);
        hw_upd(2, 1'b1, 16'h0010, 16'h0000);
        n_tests++; if (dev_state[47:32] !== 16'h0010) begin $display("FAIL excl_state got %h exp 0010", dev_state[47:32]); n_fail++; end
        bus_wr(2, 7, 16'h0001);
        n_tests++; if (irq !== 1'b0) begin $display("FAIL irq_before got %b exp 0", irq); n_fail++; end
        @(posedge clk); #1;
        n_tests++; if (irq !== 1'b1) begin $display("FAIL irq_raise got %b exp 1", irq); n_fail++; end
        bus_wr(2, 6, 16'h0001);
        n_tests++; if (irq !== 1'b1) begin $display("FAIL irq_hold got %b exp 1", irq); n_fail++; end
        @(posedge clk); #1;
        n_tests++; if (irq !== 1'b0) begin $display("FAIL irq_clear got %b exp 0", irq); n_fail++; end
        exp_q.push_back(16'h0004);
        rd(2, 6, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL excl_events got %h exp %h", got, exp_v); n_fail++; end
        bus_wr(3, 7, 16'hFFFF);
        exp_q.push_back(16'h0007);
        rd(3, 7, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL enable_mask got %h exp %h", got, exp_v); n_fail++; end
        bus_wr(3, 7, 16'h0000);
        bus_wr(2, 7, 16'h0000);
    endtask

    task automatic test_bus_priority();
        set_addr(0, 0); mem_writedata = 16'h1234; mem_write = 1'b1;
        hw_dev = 2'd0; hw_exclusive = 1'b0; hw_state = 16'h0001; hw_extra = 16'h0055; hw_valid = 1'b1;
        #1;
        n_tests++; if (hw_ready !== 1'b0) begin $display("FAIL prio_ready_low got %b exp 0", hw_ready); n_fail++; end
        @(posedge clk); #1;
        model_wr(0, 0, 16'h1234);
        n_tests++; if (dev_state[15:0] !== 16'h1234) begin $display("FAIL prio_bus_state got %h exp 1234", dev_state[15:0]); n_fail++; end
        mem_write = 1'b0;
        #1;
        n_tests++; if (hw_ready !== 1'b1) begin $display("FAIL prio_ready_high got %b exp 1", hw_ready); n_fail++; end
        @(posedge clk); #1;
        hw_valid = 1'b0;
        model_upd(0, 1'b0, 16'h0001, 16'h0055);
        n_tests++; if (dev_state[15:0] !== 16'h1235) begin $display("FAIL prio_upd_state got %h exp 1235", dev_state[15:0]); n_fail++; end
        exp_q.push_back(16'h0003);
        rd(0, 6, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL prio_events got %h exp %h", got, exp_v); n_fail++; end
        // Bus write and hardware update on different slots in one cycle
        set_addr(2, 2); mem_writedata = 16'h5A5A; mem_write = 1'b1;
        hw_dev = 2'd0; hw_state = 16'h0100; hw_extra = 16'h0055; hw_valid = 1'b1;
        #1;
        n_tests++; if (hw_ready !== 1'b1) begin $display("FAIL diff_slot_ready got %b exp 1", hw_ready); n_fail++; end
        @(posedge clk); #1;
        mem_write = 1'b0; hw_valid = 1'b0;
        model_wr(2, 2, 16'h5A5A);
        model_upd(0, 1'b0, 16'h0100, 16'h0055);
        n_tests++; if (dev_state[15:0] !== 16'h1335) begin $display("FAIL diff_slot_state got %h exp 1335", dev_state[15:0]); n_fail++; end
        exp_q.push_back(16'h5A5A);
        rd(2, 2, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL diff_slot_user got %h exp %h", got, exp_v); n_fail++; end
    endtask

    task automatic test_rw_range();
        bus_wr(1, 3, 16'hBEEF);
        exp_q.push_back(16'hBEEF);
        rd(1, 3, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL user_rw got %h exp %h", got, exp_v); n_fail++; end
        // Read data reflects contents before a same-cycle write
        set_addr(1, 3); mem_writedata = 16'hCAFE; mem_write = 1'b1;
        exp_q.push_back(16'hBEEF);
        @(posedge clk); #1;
        mem_write = 1'b0; model_wr(1, 3, 16'hCAFE);
        got = mem_readdata; exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL rd_during_wr got %h exp %h", got, exp_v); n_fail++; end
        exp_q.push_back(16'hCAFE);
        @(posedge clk); #1;
        got = mem_readdata; exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL rd_after_wr got %h exp %h", got, exp_v); n_fail++; end
        bus_wr(4, 3, 16'hDEAD);
        bus_wr(2047, 0, 16'hFFFF);
        exp_q.push_back(16'h0000);
        rd(4, 3, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL oor_rd got %h exp %h", got, exp_v); n_fail++; end
        exp_q.push_back(model_rd(0, 3));
        rd(0, 3, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL oor_alias got %h exp %h", got, exp_v); n_fail++; end
        exp_ds = model_ds();
        n_tests++; if (dev_state !== exp_ds) begin $display("FAIL oor_dev_state got %h exp %h", dev_state, exp_ds); n_fail++; end
    endtask

    task automatic test_w1c_vs_set();
        hw_upd(3, 1'b0, 16'h0001, 16'h0000);
        set_addr(3, 6); mem_writedata = 16'h0001; mem_write = 1'b1;
        hw_dev = 2'd3; hw_exclusive = 1'b0; hw_state = 16'h0002; hw_extra = 16'h0000; hw_valid = 1'b1;
        #1;
        n_tests++; if (hw_ready !== 1'b1) begin $display("FAIL w1c_ready got %b exp 1", hw_ready); n_fail++; end
        @(posedge clk); #1;
        mem_write = 1'b0; hw_valid = 1'b0;
        m_state[3] = 16'h0003; m_evt[3] = 3'b101;
        exp_q.push_back(16'h0005);
        rd(3, 6, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL w1c_set_wins got %h exp %h", got, exp_v); n_fail++; end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            hw_dev = 2'($urandom_range(0, 3));
            hw_exclusive = 1'($urandom_range(0, 1));
            hw_state = 16'($urandom_range(0, 65535));
            hw_extra = 16'($urandom_range(0, 3));
            hw_valid = 1'b1;
            @(posedge clk); #1;
            model_upd(int'(hw_dev), hw_exclusive, hw_state, hw_extra);
        end
        hw_valid = 1'b0;
        exp_ds = model_ds();
        n_tests++; if (dev_state !== exp_ds) begin $display("FAIL b2b_dev_state got %h exp %h", dev_state, exp_ds); n_fail++; end
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back(model_rd(d, 1));
            rd(d, 1, got); exp_v = exp_q.pop_front();
            n_tests++; if (got !== exp_v) begin $display("FAIL b2b_extra_s%0d got %h exp %h", d, got, exp_v); n_fail++; end
            exp_q.push_back(model_rd(d, 6));
            rd(d, 6, got); exp_v = exp_q.pop_front();
            n_tests++; if (got !== exp_v) begin $display("FAIL b2b_events_s%0d got %h exp %h", d, got, exp_v); n_fail++; end
        end
        n_tests++; if (irq !== 1'b0) begin $display("FAIL b2b_irq got %b exp 0", irq); n_fail++; end
    endtask

    task automatic test_reset_mid();
        set_addr(1, 0);
        hw_dev = 2'd1; hw_exclusive = 1'b1; hw_state = 16'hFFFF; hw_extra = 16'hFFFF; hw_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        n_tests++; if (dev_state !== 64'h0) begin $display("FAIL mid_rst_dev_state got %h exp 0", dev_state); n_fail++; end
        n_tests++; if (mem_readdata !== 16'h0) begin $display("FAIL mid_rst_readdata got %h exp 0", mem_readdata); n_fail++; end
        n_tests++; if (hw_ready !== 1'b1) begin $display("FAIL mid_rst_ready got %b exp 1", hw_ready); n_fail++; end
        @(posedge clk); #1;
        hw_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (dev_state !== 64'h0) begin $display("FAIL mid_rst_lost got %h exp 0", dev_state); n_fail++; end
        hw_upd(1, 1'b0, 16'h0008, 16'h0001);
        n_tests++; if (dev_state[31:16] !== 16'h0008) begin $display("FAIL post_rst_state got %h exp 0008", dev_state[31:16]); n_fail++; end
        exp_q.push_back(16'h0003);
        rd(1, 6, got); exp_v = exp_q.pop_front();
        n_tests++; if (got !== exp_v) begin $display("FAIL post_rst_events got %h exp %h", got, exp_v); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_hw_or();
        test_exclusive_irq();
        test_bus_priority();
        test_rw_range();
        test_w1c_vs_set();
        test_back_to_back();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_leftover got %0d entries exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dircc_status_regfile.md
DIRCC_STATUS_REGFILE -- requirements
Module: dircc_status_regfile

Interface
REQ-001 SHALL have parameter NUM_DEVS, default 4, number of device status slots (1..64).
REQ-002 SHALL have parameter MEM_WIDTH, default 16, bus data width; fixed, not overridable.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 15, bus byte-address width.
REQ-004 SHALL have parameter BYTE_WIDTH, default 8, storage byte width.
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port mem_address  input  ADDRESS_WIDTH  byte address; bit 0 ignored.
REQ-008 SHALL have port mem_write  input  1  bus write strobe.
REQ-009 SHALL have port mem_writedata  input  MEM_WIDTH  bus write data.
REQ-010 SHALL have port mem_readdata  output  MEM_WIDTH  registered read data.
REQ-011 SHALL have port hw_valid  input  1  hardware state-update request.
REQ-012 SHALL have port hw_ready  output  1  update accepted when hw_valid && hw_ready.
REQ-013 SHALL have port hw_dev  input  $clog2(NUM_DEVS) (min 1)  target slot.
REQ-014 SHALL have port hw_exclusive  input  1  0 = OR into state, 1 = overwrite state.
REQ-015 SHALL have port hw_state  input  16  state bits.
REQ-016 SHALL have port hw_extra  input  16  extra-data word, always overwritten.
REQ-017 SHALL have port dev_state  output  NUM_DEVS*16  state word of slot i at [16i+15:16i].
REQ-018 SHALL have port irq  output  1  registered interrupt, level.

Function
REQ-019 Address map SHALL be: slot = address[ADDRESS_WIDTH-1:4], halfword w = address[3:1].
REQ-020 Per slot: w0 state, w1 extra, w2..w5 user state (64 bits), w6 event flags, w7 irq enable; bytes stored little-endian.
REQ-021 w0..w5 and w7 SHALL be bus read/write; w7 bits [15:3] SHALL read 0 and ignore writes.
REQ-022 w6 SHALL be write-1-to-clear on bits [2:0]; bits [15:3] read 0.
REQ-023 Slot >= NUM_DEVS SHALL read 0 and ignore writes.
REQ-024 mem_readdata SHALL be updated every cycle with the addressed halfword; 1-cycle latency; value reflects contents before a same-cycle write.
REQ-025 hw_ready SHALL be 0 only when mem_write targets w0 or w1 of slot hw_dev (bus priority); else 1; combinational.
REQ-026 On accepted update: state <= hw_exclusive ? hw_state : (state | hw_state); extra <= hw_extra; takes effect next edge.
REQ-027 Accepted update SHALL set event bit0 if new state != old state, bit1 if new extra != old extra.
REQ-028 Accepted update setting bit0 while bit0 already 1 SHALL set event bit2 (overflow).
REQ-029 Same-cycle W1C and event set on same bit: set SHALL win.
REQ-030 Bus writes to w0/w1 SHALL NOT set event bits.
REQ-031 irq SHALL be registered OR over all slots of (event[2:0] & enable[2:0]); 1 cycle after cause.
REQ-032 dev_state SHALL reflect stored w0 combinationally from registers (no added latency).
REQ-033 Bus write and accepted hw update to different slots in the same cycle SHALL both complete.

Reset
REQ-034 reset_n low SHALL asynchronously clear all slot storage, events, enables, mem_readdata, irq to 0.
REQ-035 hw_ready SHALL be 1 during and after reset (no bus write pending); updates presented during reset are lost.
REQ-036 Reset asserted mid-update SHALL leave no partial state; first edge after release behaves per REQ-024..031.

Verification
REQ-037 Reset, read slot0 w0..w7 -> all 0x0000, irq 0, dev_state 0.
REQ-038 hw update slot1 OR 0x0003 extra 0x00AA, then OR 0x0004 -> dev_state[31:16]=0x0007, w1=0x00AA, w6=0x0007 (bit2 overflow set).
REQ-039 Exclusive update slot2 0x0010 over 0x00FF -> state 0x0010; enable w7=0x0001 -> irq 1 next cycle; write w6=0x0001 -> irq 0 one cycle after clear.
REQ-040 Same cycle: bus write slot0 w0=0x1234 and hw_valid to slot0 -> hw_ready 0, state 0x1234, update applied next cycle (OR result 0x1234|hw_state).
REQ-041 Write w3=0xBEEF then read w3 -> 0xBEEF one cycle after address; read address beyond NUM_DEVS*16 -> 0x0000, write ignored.
REQ-042 Same cycle W1C of bit0 and accepted update changing state -> event bit0 remains 1.
